// File: rtl/riscv_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package riscv_lsu_pkg;

    localparam int LSU_SIZE_LEN  = 2;
    localparam int LSU_STATE_LEN = 2;

    typedef enum logic [LSU_SIZE_LEN-1:0] {
        LSU_SIZE_B = 2'd0,
        LSU_SIZE_H = 2'd1,
        LSU_SIZE_W = 2'd2,
        LSU_SIZE_D = 2'd3
    } lsu_size_e;

    typedef enum logic [LSU_STATE_LEN-1:0] {
        LSU_STATE_IDLE   = 2'd0,
        LSU_STATE_ACCESS = 2'd1,
        LSU_STATE_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction
// and access legality for one request.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic [ADDR_W-1:0] word_addr,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              access_err
);

    localparam int   NB     = XLEN / 8;
    localparam int   OFF_W  = $clog2(NB);
    localparam logic STRICT = (ALLOW_MISALIGNED == 0);

    logic [OFF_W-1:0] off_s;
    logic [OFF_W-1:0] align_mask_s;
    logic [OFF_W-1:0] eff_off_s;
    logic [NB-1:0]    size_mask_s;
    logic             illegal_size_s;
    logic             misaligned_s;
    logic [XLEN-1:0]  shifted_s;
    logic [XLEN-1:0]  keep_s;
    logic             sign_s;

    assign off_s        = addr[OFF_W-1:0];
    assign misaligned_s = |(off_s & align_mask_s);
    // Misaligned offsets are rounded down to natural alignment when tolerated
    assign eff_off_s    = off_s & ~align_mask_s;
    assign access_err   = illegal_size_s | (misaligned_s & STRICT);
    assign word_addr    = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign be           = size_mask_s << eff_off_s;
    assign shifted_s    = mem_rdata >> {eff_off_s, 3'b000};

    // Decode size into lane mask, low-address alignment mask and legality
    always_comb begin
        size_mask_s    = {NB{1'b0}};
        align_mask_s   = {OFF_W{1'b0}};
        illegal_size_s = 1'b0;
        case (lsu_size_e'(size))
            LSU_SIZE_B: begin
                size_mask_s  = NB'(8'h01);
                align_mask_s = OFF_W'(3'b000);
            end
            LSU_SIZE_H: begin
                size_mask_s  = NB'(8'h03);
                align_mask_s = OFF_W'(3'b001);
            end
            LSU_SIZE_W: begin
                size_mask_s  = NB'(8'h0F);
                align_mask_s = OFF_W'(3'b011);
            end
            LSU_SIZE_D: begin
                if (XLEN == 64) begin
                    size_mask_s  = NB'(8'hFF);
                    align_mask_s = OFF_W'(3'b111);
                end else begin
                    illegal_size_s = 1'b1;
                end
            end
            default: illegal_size_s = 1'b1;
        endcase
    end

    // Replicate right-aligned store data across every lane of its size
    always_comb begin
        lane_wdata = {XLEN{1'b0}};
        case (lsu_size_e'(size))
            LSU_SIZE_B: lane_wdata = {NB{wdata[7:0]}};
            LSU_SIZE_H: lane_wdata = {(NB/2){wdata[15:0]}};
            LSU_SIZE_W: lane_wdata = {(NB/4){wdata[31:0]}};
            LSU_SIZE_D: lane_wdata = wdata;
            default:    lane_wdata = {XLEN{1'b0}};
        endcase
    end

    // Keep the addressed lanes and extend from the top bit of the access size
    always_comb begin
        keep_s = {XLEN{1'b0}};
        sign_s = 1'b0;
        case (lsu_size_e'(size))
            LSU_SIZE_B: begin
                keep_s = XLEN'(64'h0000_0000_0000_00FF);
                sign_s = shifted_s[7];
            end
            LSU_SIZE_H: begin
                keep_s = XLEN'(64'h0000_0000_0000_FFFF);
                sign_s = shifted_s[15];
            end
            LSU_SIZE_W: begin
                keep_s = XLEN'(64'h0000_0000_FFFF_FFFF);
                sign_s = shifted_s[31];
            end
            LSU_SIZE_D: begin
                keep_s = {XLEN{1'b1}};
                sign_s = shifted_s[XLEN-1];
            end
            default: begin
                keep_s = {XLEN{1'b0}};
                sign_s = 1'b0;
            end
        endcase
        if (sign_s && !load_unsigned) begin
            load_data = (shifted_s & keep_s) | ~keep_s;
        end else begin
            load_data = shifted_s & keep_s;
        end
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one request, runs a req/ack memory access with
// any number of wait states and returns an extended result or an error.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter int ALLOW_MISALIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN/8-1:0] mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int NB = XLEN / 8;

    lsu_state_e        state_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [ADDR_W-1:0] addr_r;
    logic [XLEN-1:0]   wdata_r;

    logic              req_ready_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_rdata_r;
    logic              resp_err_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [NB-1:0]     mem_be_r;
    logic [XLEN-1:0]   mem_wdata_r;

    logic [1:0]        a_size_s;
    logic              a_unsigned_s;
    logic [ADDR_W-1:0] a_addr_s;
    logic [XLEN-1:0]   a_wdata_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [NB-1:0]     be_s;
    logic [XLEN-1:0]   lane_wdata_s;
    logic [XLEN-1:0]   load_data_s;
    logic              access_err_s;

    // Feed the incoming request to the lane logic while idle, the latched one afterwards
    always_comb begin
        if (state_r == LSU_STATE_IDLE) begin
            a_size_s     = req_size;
            a_unsigned_s = req_unsigned;
            a_addr_s     = req_addr;
            a_wdata_s    = req_wdata;
        end else begin
            a_size_s     = size_r;
            a_unsigned_s = unsigned_r;
            a_addr_s     = addr_r;
            a_wdata_s    = wdata_r;
        end
    end

    riscv_lsu_align #(
        .XLEN             (XLEN),
        .ADDR_W           (ADDR_W),
        .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
    ) u_align (
        .size          (a_size_s),
        .load_unsigned (a_unsigned_s),
        .addr          (a_addr_s),
        .wdata         (a_wdata_s),
        .mem_rdata     (mem_rdata),
        .word_addr     (word_addr_s),
        .be            (be_s),
        .lane_wdata    (lane_wdata_s),
        .load_data     (load_data_s),
        .access_err    (access_err_s)
    );

    // Request FSM with registered handshake and memory-port outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= LSU_STATE_IDLE;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {XLEN{1'b0}};
            req_ready_r  <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= {XLEN{1'b0}};
            resp_err_r   <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_be_r     <= {NB{1'b0}};
            mem_wdata_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                LSU_STATE_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        write_r     <= req_write;
                        size_r      <= req_size;
                        unsigned_r  <= req_unsigned;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        req_ready_r <= 1'b0;
                        if (access_err_s) begin
                            state_r      <= LSU_STATE_RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                            resp_rdata_r <= {XLEN{1'b0}};
                        end else begin
                            state_r     <= LSU_STATE_ACCESS;
                            mem_req_r   <= 1'b1;
                            mem_we_r    <= req_write;
                            mem_addr_r  <= word_addr_s;
                            mem_be_r    <= be_s;
                            mem_wdata_r <= lane_wdata_s;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                LSU_STATE_ACCESS: begin
                    if (mem_ack) begin
                        state_r      <= LSU_STATE_RESP;
                        mem_req_r    <= 1'b0;
                        mem_we_r     <= 1'b0;
                        mem_addr_r   <= {ADDR_W{1'b0}};
                        mem_be_r     <= {NB{1'b0}};
                        mem_wdata_r  <= {XLEN{1'b0}};
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= mem_err;
                        // Stores and bus errors never return data
                        if (mem_err || write_r) begin
                            resp_rdata_r <= {XLEN{1'b0}};
                        end else begin
                            resp_rdata_r <= load_data_s;
                        end
                    end
                end
                LSU_STATE_RESP: begin
                    state_r      <= LSU_STATE_IDLE;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    req_ready_r  <= 1'b1;
                end
                default: begin
                    state_r      <= LSU_STATE_IDLE;
                    req_ready_r  <= 1'b0;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= {XLEN{1'b0}};
                    mem_req_r    <= 1'b0;
                    mem_we_r     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;
    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_be     = mem_be_r;
    assign mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench: a 32-bit strict LSU and a 64-bit misalignment-tolerant LSU share one
// request/memory stimulus and are compared against an arithmetic access model.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        mem_ack, mem_err;
    logic [63:0] mem_rdata;

    logic        r32_ready, r32_valid, r32_err, m32_req, m32_we;
    logic [31:0] r32_rdata, m32_addr, m32_wdata;
    logic [3:0]  m32_be;
    logic        r64_ready, r64_valid, r64_err, m64_req, m64_we;
    logic [63:0] r64_rdata, m64_wdata;
    logic [31:0] m64_addr;
    logic [7:0]  m64_be;

    int checks = 0;
    int errors = 0;

    logic        o_req[2], o_rv[2], o_rdy[2], o_we[2], o_err[2];
    logic [63:0] o_addr[2], o_be[2], o_wd[2], o_rd[2];
    logic [63:0] last_rdata[2], first_addr[2], first_be[2], first_wdata[2];
    logic        last_err[2];
    int          req_cycles[2], resp_cycle[2];

    always #5 clk = ~clk;

    riscv_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r32_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .resp_valid(r32_valid),
        .resp_rdata(r32_rdata), .resp_err(r32_err), .mem_req(m32_req), .mem_we(m32_we),
        .mem_addr(m32_addr), .mem_be(m32_be), .mem_wdata(m32_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
    );

    riscv_lsu #(.XLEN(64), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r64_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(r64_valid),
        .resp_rdata(r64_rdata), .resp_err(r64_err), .mem_req(m64_req), .mem_we(m64_we),
        .mem_addr(m64_addr), .mem_be(m64_be), .mem_wdata(m64_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        o_req[0] = m32_req;  o_rv[0] = r32_valid; o_rdy[0] = r32_ready; o_we[0] = m32_we;
        o_err[0] = r32_err;  o_addr[0] = {32'h0, m32_addr}; o_be[0] = {60'h0, m32_be};
        o_wd[0] = {32'h0, m32_wdata}; o_rd[0] = {32'h0, r32_rdata};
        o_req[1] = m64_req;  o_rv[1] = r64_valid; o_rdy[1] = r64_ready; o_we[1] = m64_we;
        o_err[1] = r64_err;  o_addr[1] = {32'h0, m64_addr}; o_be[1] = {56'h0, m64_be};
        o_wd[1] = m64_wdata; o_rd[1] = r64_rdata;
    endtask

    // ---- reference model: byte-level arithmetic on the access rules ----
    function automatic int eff_off(int xlen, bit allow, logic [1:0] sz, logic [31:0] addr);
        int nb = xlen / 8;
        int bytes = 1 << sz;
        int off = int'(addr % nb);
        if (allow) off = off - (off % bytes);
        return off;
    endfunction

    function automatic bit m_err(int xlen, bit allow, logic [1:0] sz, logic [31:0] addr);
        int bytes = 1 << sz;
        if (xlen == 32 && sz == 2'd3) return 1'b1;
        return !allow && (addr % bytes != 0);
    endfunction

    function automatic logic [63:0] m_be(int xlen, bit allow, logic [1:0] sz, logic [31:0] addr);
        int bytes = 1 << sz;
        logic [63:0] r = 64'h0;
        for (int i = 0; i < bytes; i++) r[eff_off(xlen, allow, sz, addr) + i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(int xlen, logic [1:0] sz, logic [63:0] wd);
        int bytes = 1 << sz;
        logic [63:0] r = 64'h0;
        for (int i = 0; i < xlen / 8; i++) r[i*8 +: 8] = wd[(i % bytes)*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_rdata(int xlen, bit allow, logic [1:0] sz, logic [31:0] addr,
                                            logic [63:0] word, bit uns);
        int bits = (1 << sz) * 8;
        logic [63:0] keep = (bits < 64) ? ((64'd1 << bits) - 64'd1) : 64'hFFFF_FFFF_FFFF_FFFF;
        logic [63:0] v;
        if (xlen == 32) word = word & 64'h0000_0000_FFFF_FFFF;
        v = (word >> (eff_off(xlen, allow, sz, addr) * 8)) & keep;
        if (!uns && v[bits-1]) v = v | ~keep;
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    // One complete transaction on both units; ack arrives in the (k+1)-th cycle after accept.
    task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [63:0] rd, input int k, input logic merr);
        bit          e_err[2];
        logic [63:0] e_addr[2], e_be[2], e_wd[2], e_rd[2];
        logic        e_rerr[2];
        for (int d = 0; d < 2; d++) begin
            int xl = (d == 0) ? 32 : 64;
            bit al = (d == 1);
            logic [63:0] nbm = (d == 0) ? 64'd4 : 64'd8;
            e_err[d]  = m_err(xl, al, sz, addr);
            e_addr[d] = {32'h0, addr} - ({32'h0, addr} % nbm);
            e_be[d]   = m_be(xl, al, sz, addr);
            e_wd[d]   = m_wdata(xl, sz, wd);
            e_rd[d]   = (e_err[d] || wr || merr) ? 64'h0 : m_rdata(xl, al, sz, addr, rd, uns);
            e_rerr[d] = e_err[d] ? 1'b1 : merr;
            req_cycles[d] = 0; resp_cycle[d] = 0;
            first_addr[d] = 64'h0; first_be[d] = 64'h0; first_wdata[d] = 64'h0;
        end
        for (int n = 0; n < 20 && !(r32_ready && r64_ready); n++) @(negedge clk);
        chk("ready_before_req", {63'h0, r32_ready & r64_ready}, 64'h1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        for (int c = 1; c <= k + 3; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
            req_addr = $urandom; req_wdata = {$urandom, $urandom};
            mem_ack   = (c == k + 1);
            mem_rdata = (c == k + 1) ? rd : {$urandom, $urandom};
            mem_err   = (c == k + 1) ? merr : 1'($urandom);
            sample();
            for (int d = 0; d < 2; d++) begin
                bit x_req = !e_err[d] && (c <= k + 1);
                bit x_rv  = e_err[d] ? (c == 1) : (c == k + 2);
                bit x_rdy = e_err[d] ? (c >= 2) : (c >= k + 3);
                string p = (d == 0) ? "x32" : "x64";
                if (o_req[d]) req_cycles[d]++;
                if (o_rv[d] && resp_cycle[d] == 0) resp_cycle[d] = c;
                chk({p, "_mem_req"}, {63'h0, o_req[d]}, {63'h0, x_req});
                chk({p, "_resp_valid"}, {63'h0, o_rv[d]}, {63'h0, x_rv});
                chk({p, "_req_ready"}, {63'h0, o_rdy[d]}, {63'h0, x_rdy});
                if (x_req) begin
                    if (c == 1) begin
                        first_addr[d] = o_addr[d]; first_be[d] = o_be[d]; first_wdata[d] = o_wd[d];
                    end
                    chk({p, "_mem_we"}, {63'h0, o_we[d]}, {63'h0, wr});
                    chk({p, "_mem_addr"}, o_addr[d], e_addr[d]);
                    chk({p, "_mem_be"}, o_be[d], e_be[d]);
                    chk({p, "_mem_wdata"}, o_wd[d], e_wd[d]);
                end
                if (x_rv) begin
                    last_rdata[d] = o_rd[d]; last_err[d] = o_err[d];
                    chk({p, "_resp_rdata"}, o_rd[d], e_rd[d]);
                    chk({p, "_resp_err"}, {63'h0, o_err[d]}, {63'h0, e_rerr[d]});
                end
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 64'h0; mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 64'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready32", {63'h0, r32_ready}, 64'h0);
        chk("rst_ready64", {63'h0, r64_ready}, 64'h0);
        chk("rst_outs", {58'h0, m32_req, m64_req, r32_valid, r64_valid, r32_err, r64_err}, 64'h0);
        chk("rst_data", {32'h0, m32_addr} | r64_rdata | m64_wdata, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {62'h0, r32_ready, r64_ready}, 64'h3);

        // byte load, sign from bit 7, zero wait states
        run_txn(1'b0, 2'd0, 1'b0, 32'h103, 64'h0, 64'h0000_0000_80FF_1234, 0, 1'b0);
        chk("lb_rdata32", last_rdata[0], 64'h0000_0000_FFFF_FF80);
        chk("lb_be32", first_be[0], 64'h8);
        chk("lb_latency32", 64'(resp_cycle[0]), 64'd2);
        chk("lb_rdata64", last_rdata[1], 64'hFFFF_FFFF_FFFF_FF80);

        // half store with three wait states
        run_txn(1'b1, 2'd1, 1'b0, 32'h202, 64'hBEEF, 64'h1234_5678_9ABC_DEF0, 3, 1'b0);
        chk("sh_addr32", first_addr[0], 64'h200);
        chk("sh_be32", first_be[0], 64'hC);
        chk("sh_wdata32", first_wdata[0], 64'hBEEF_BEEF);
        chk("sh_req_cycles32", 64'(req_cycles[0]), 64'd4);
        chk("sh_latency32", 64'(resp_cycle[0]), 64'd5);
        chk("sh_rdata32", last_rdata[0], 64'h0);
        chk("sh_wdata64", first_wdata[1], 64'hBEEF_BEEF_BEEF_BEEF);

        // misaligned word: error on the strict unit, truncated on the tolerant one
        run_txn(1'b0, 2'd2, 1'b0, 32'h6, 64'h0, 64'h8765_4321_0000_0000, 1, 1'b0);
        chk("mis_err32", {63'h0, last_err[0]}, 64'h1);
        chk("mis_req32", 64'(req_cycles[0]), 64'd0);
        chk("mis_latency32", 64'(resp_cycle[0]), 64'd1);
        chk("mis_be64", first_be[1], 64'hF0);
        chk("mis_rdata64", last_rdata[1], 64'hFFFF_FFFF_8765_4321);

        run_txn(1'b0, 2'd1, 1'b1, 32'h2, 64'h0, 64'h0000_0000_9ABC_0000, 0, 1'b0);
        chk("lhu_rdata32", last_rdata[0], 64'h0000_0000_0000_9ABC);
        run_txn(1'b0, 2'd1, 1'b0, 32'h2, 64'h0, 64'h0000_0000_9ABC_0000, 2, 1'b0);
        chk("lh_rdata32", last_rdata[0], 64'h0000_0000_FFFF_9ABC);

        run_txn(1'b0, 2'd2, 1'b0, 32'h40, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b1);
        chk("buserr_err32", {63'h0, last_err[0]}, 64'h1);
        chk("buserr_rdata32", last_rdata[0], 64'h0);

        run_txn(1'b0, 2'd3, 1'b0, 32'h8, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 1'b0);
        chk("ld_rdata64", last_rdata[1], 64'h0123_4567_89AB_CDEF);
        chk("ld_err32", {63'h0, last_err[0]}, 64'h1);

        // reset in the middle of a long access
        for (int n = 0; n < 20 && !(r32_ready && r64_ready); n++) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_req_active", {62'h0, m32_req, m64_req}, 64'h3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_req_drop", {62'h0, m32_req, m64_req}, 64'h0);
        chk("rstmid_no_resp", {62'h0, r32_valid, r64_valid}, 64'h0);
        chk("rstmid_not_ready", {62'h0, r32_ready, r64_ready}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_ready", {62'h0, r32_ready, r64_ready}, 64'h3);
        mem_ack = 1'b1; mem_err = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray_ack_ignored", {60'h0, r32_valid, r64_valid, m32_req, m64_req}, 64'h0);

        for (int t = 0; t < 200; t++) begin
            run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom & 32'h0000_FFFF,
                    {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit replacing the fixed data-memory read mux and direct data-cache hookup in the single-cycle core.
- Accepts one load/store request per transaction from the core through a valid/ready handshake.
- Drives a word-organised memory port with byte enables and tolerates any number of wait states (req/ack).
- Returns a sign- or zero-extended load result, with lane selection by address offset.
- Flags misaligned and bus-error accesses instead of silently corrupting data.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- ALLOW_MISALIGNED, 0. When 0, a misaligned access completes with resp_err and no memory access. When 1, the address is truncated to natural alignment.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (XLEN=64 only)
- req_unsigned  in  1  zero-extend load result (LBU/LHU/LWU)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or mem_err
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  address with low log2(XLEN/8) bits zeroed
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-replicated store data
- mem_ack  in  1  memory done; rdata/err valid in the same cycle
- mem_rdata  in  XLEN  full memory word
- mem_err  in  1  bus error, qualified by mem_ack

Behaviour:
- Reset: state IDLE; req_ready=1 in the cycle after rst deasserts. While rst is high, req_ready=0. All other outputs are 0 during reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. Accept when req_valid. Latch write, size, unsigned, addr, wdata.
  - If the access is misaligned (half: addr[0]; word: addr[1:0]; double: addr[2:0]) and ALLOW_MISALIGNED=0 -> go to RESP with err=1.
  - size=3 with XLEN=32 is illegal -> go to RESP with err=1.
  - Otherwise -> go to ACCESS.
- ACCESS: mem_req=1 with mem_we/addr/be/wdata stable until mem_ack.
  - On mem_ack, register the extracted data (or err) and go to RESP.
  - mem_ack in the first ACCESS cycle is legal (zero wait states).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No back-to-back accept, because req_ready=0 in RESP.
- Latency: accept at cycle T -> mem_req from T+1 -> ack at T+1+k -> resp_valid at T+2+k. Error path: resp_valid at T+1.
- Byte enables are the size mask shifted by addr offset: byte 0x1, half 0x3, word 0xF, double 0xFF.
- Store data replication: byte replicated to every lane, half to every half lane, word to both words when XLEN=64.
- Load extraction: shift mem_rdata right by offset*8, mask to size, then sign-extend from the size MSB unless req_unsigned. A byte load sign-extends from bit 7, never bit 15.
- Error response: resp_rdata=0 and resp_err=1. Stores also return resp_rdata=0.
- rst mid-ACCESS: mem_req drops in the next cycle, no resp_valid, return to IDLE. The memory must tolerate an abandoned request.
- mem_ack outside ACCESS is ignored.

Decomposition:
- Add to riscv_defs.v:
  - LSU_SIZE_B/H/W/D (width LSU_SIZE_LEN=2)
  - LSU_STATE_IDLE/ACCESS/RESP (LSU_STATE_LEN=2)
- One combinational sub-module, riscv_lsu_align, containing:
  - be/wdata generation from size+offset
  - rdata extraction+extension
  - misalign/illegal-size detection
- riscv_lsu holds only the FSM and latches.

Test Plan:
- XLEN=32, load byte addr 0x103, mem_rdata 0x80FF_1234, unsigned=0, 0 wait states -> resp_rdata 0xFFFF_FF80, resp_valid at T+2, mem_be 0x8.
- Store half 0xBEEF to 0x202, 3 wait states -> mem_addr 0x200, mem_be 0xC, mem_wdata 0xBEEF_BEEF, mem_req high 4 cycles, resp_valid at T+5, resp_rdata 0.
- Load word 0x0000_0006, ALLOW_MISALIGNED=0 -> no mem_req ever, resp_valid+resp_err at T+1.
- Load half unsigned 0x002, mem_rdata 0x9ABC_0000 -> 0x0000_9ABC. Same with unsigned=0 -> 0xFFFF_9ABC.
- Load word with mem_ack+mem_err=1 -> resp_err=1, resp_rdata 0. rst asserted during a 5-wait ACCESS -> mem_req low next cycle, no resp_valid, req_ready=1 one cycle after rst drops.
- XLEN=64: load double 0x8 returns the full mem_rdata. size=3 with XLEN=32 gives resp_err.
